// File: rtl/lfsr_checker.sv
// Receive-side checker for the 32-bit Fibonacci LFSR random-bit source.
// Self-seeds from 32 valid bits, predicts each following bit, and counts and windows mismatches.
module lfsr_checker #(
  parameter int WINDOW       = 64,
  parameter int LOCK_ERR_MAX = 4,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WERR_W = $clog2(LOCK_ERR_MAX + 1);

  typedef enum logic {HUNT, CHECK} state_e;

  state_e               state_q, state_d;
  logic [31:0]          s_q, s_d;
  logic [4:0]           fill_q, fill_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]    win_err_q, win_err_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                 predict;
  logic                 mismatch;
  logic [WERR_W-1:0]    win_err_inc;

  assign predict = s_q[31] ^ s_q[29] ^ s_q[25] ^ s_q[24];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    mismatch    = 1'b0;
    win_err_inc = win_err_q;

    if (bit_valid) begin
      unique case (state_q)
        HUNT: begin
          s_d = {s_q[30:0], bit_in};
          if (fill_q == 5'd31) begin
            fill_d = '0;
            // An all-zero seed would predict zeros forever, so it never locks.
            if (s_d != 32'd0) state_d = CHECK;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        CHECK: begin
          mismatch    = bit_in ^ predict;
          // Shift the prediction so a single corrupted bit is counted exactly once.
          s_d         = {s_q[30:0], predict};
          err_pulse_d = mismatch;
          win_err_inc = win_err_q + WERR_W'(mismatch);
          if (win_err_inc == WERR_W'(LOCK_ERR_MAX)) begin
            state_d   = HUNT;
            fill_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = win_err_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clear_cnt) begin
      err_count_d = '0;
    end else if (mismatch && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    locked_d = (state_d == CHECK);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      s_q         <= '0;
      fill_q      <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default instance plus a 4-bit-counter instance with
// LOCK_ERR_MAX=WINDOW for the saturation and clear-priority cases.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked_s, err_pulse_s;
  logic [3:0]  err_count_s;

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic [31:0] src    = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  lfsr_checker #(.WINDOW(64), .LOCK_ERR_MAX(64), .ERR_CNT_W(4)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked_s),
    .err_pulse (err_pulse_s),
    .err_count (err_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference source: seed all-ones, emits the new feedback bit each step.
  task automatic gen(output logic b);
    b   = src[31] ^ src[29] ^ src[25] ^ src[24];
    src = {src[30:0], b};
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic b, input logic v, input logic clr);
    @(negedge clk);
    bit_in    = b;
    bit_valid = v;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    if (err_pulse) pulses++;
  endtask

  task automatic src_bit(input logic inv);
    logic b;
    gen(b);
    step(b ^ inv, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
    bit_in    = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    int nvalid;
    logic v;
    logic b;

    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear_cnt = 1'b0;
    do_reset();
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pulse", 32'(err_pulse), 32'd0);
    check("rst_count", 32'(err_count), 32'd0);

    // 1: clean stream locks after bit 32 and stays error-free.
    for (int i = 0; i < 31; i++) src_bit(1'b0);
    check("t1_not_locked_31", 32'(locked), 32'd0);
    src_bit(1'b0);
    check("t1_locked_32", 32'(locked), 32'd1);
    p0 = pulses;
    for (int i = 0; i < 1000; i++) src_bit(1'b0);
    check("t1_count", 32'(err_count), 32'd0);
    check("t1_pulses", 32'(pulses - p0), 32'd0);
    check("t1_locked", 32'(locked), 32'd1);

    // 2: single inverted bit #100 counts once, lock held.
    p0 = pulses;
    for (int i = 1; i <= 150; i++) begin
      src_bit(i == 100);
      if (i == 100) check("t2_pulse_now", 32'(err_pulse), 32'd1);
      if (i == 101) check("t2_pulse_gone", 32'(err_pulse), 32'd0);
    end
    check("t2_pulses", 32'(pulses - p0), 32'd1);
    check("t2_count", 32'(err_count), 32'd1);
    check("t2_locked", 32'(locked), 32'd1);

    // 3: four errors in one window drop lock; 32 clean bits relock.
    do_reset();
    for (int i = 0; i < 32; i++) src_bit(1'b0);
    check("t3_locked", 32'(locked), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      src_bit((i % 5) == 0);
      if (i == 15) check("t3_locked_after3", 32'(locked), 32'd1);
    end
    check("t3_unlocked", 32'(locked), 32'd0);
    check("t3_count", 32'(err_count), 32'd4);
    for (int i = 0; i < 31; i++) src_bit(1'b0);
    check("t3_hunt_31", 32'(locked), 32'd0);
    src_bit(1'b0);
    check("t3_relocked", 32'(locked), 32'd1);
    for (int i = 0; i < 100; i++) src_bit(1'b0);
    check("t3_count_after", 32'(err_count), 32'd4);

    // 4: ~30% valid duty; invalid cycles carry junk that must be ignored.
    do_reset();
    nvalid = 0;
    while (nvalid < 32) begin
      v = ($urandom_range(0, 9) < 3);
      if (v) begin
        gen(b);
        step(b, 1'b1, 1'b0);
        nvalid++;
        if (nvalid == 31) check("t4_not_locked_31", 32'(locked), 32'd0);
      end else begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    check("t4_locked", 32'(locked), 32'd1);
    p0 = pulses;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 9) < 3);
      if (v) begin
        gen(b);
        step(b, 1'b1, 1'b0);
      end else begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    check("t4_count", 32'(err_count), 32'd0);
    check("t4_pulses", 32'(pulses - p0), 32'd0);

    // 5a: all-zero stream never locks.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 32) check("t5_zero_32", 32'(locked), 32'd0);
    end
    check("t5_zero_40", 32'(locked), 32'd0);
    check("t5_zero_count", 32'(err_count), 32'd0);

    // 5b: 4-bit counter saturates at 15; clear beats a coincident error.
    do_reset();
    for (int i = 0; i < 32; i++) src_bit(1'b0);
    check("t5_sat_locked", 32'(locked_s), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      src_bit(1'b1);
      if (i == 14) check("t5_cnt_14", 32'(err_count_s), 32'd14);
      if (i == 15) check("t5_cnt_15", 32'(err_count_s), 32'd15);
    end
    check("t5_cnt_sat", 32'(err_count_s), 32'd15);
    gen(b);
    step(~b, 1'b1, 1'b1);
    check("t5_clr_count", 32'(err_count_s), 32'd0);
    check("t5_clr_pulse", 32'(err_pulse_s), 32'd1);
    src_bit(1'b1);
    check("t5_after_clr", 32'(err_count_s), 32'd1);
    check("t5_sat_still_locked", 32'(locked_s), 32'd1);

    // 6: asynchronous reset mid-CHECK takes effect before the next edge.
    do_reset();
    for (int i = 0; i < 42; i++) src_bit(1'b0);
    src_bit(1'b1);
    check("t6_pre_count", 32'(err_count), 32'd1);
    check("t6_pre_locked", 32'(locked), 32'd1);
    @(negedge clk);
    bit_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_locked", 32'(locked), 32'd0);
    check("t6_async_count", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 31; i++) src_bit(1'b0);
    check("t6_hunt_31", 32'(locked), 32'd0);
    src_bit(1'b0);
    check("t6_relocked", 32'(locked), 32'd1);
    for (int i = 0; i < 50; i++) src_bit(1'b0);
    check("t6_count", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
